// File: rtl/branch_predictor.sv
// Direct-mapped branch history/target table: zero-latency fetch lookup,
// execute-side training and a registered mispredict/redirect to the PC mux.
module branch_predictor #(
    parameter int ENTRIES = 16,
    localparam int IDXW = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        predTaken,
    output logic [31:0] predPc,
    input  logic        updEn,
    input  logic [31:0] updPc,
    input  logic        updTaken,
    input  logic [31:0] updTarget,
    input  logic        updPredTaken,
    input  logic [31:0] updPredPc,
    output logic        mispredict,
    output logic [31:0] redirectPc
);

    localparam int TAGW = 32 - IDXW - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic        mispredict_q, mispredict_d;
    logic [31:0] redirectPc_q, redirectPc_d;

    logic [IDXW-1:0] idxF, idxU;
    logic [TAGW-1:0] tagF, tagU;
    logic            hitF, hitU;

    logic            wrEn;
    logic [31:0]     wrTarget;
    logic [1:0]      wrCtr;
    logic [31:0]     correctPc;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    assign idxF = pcF[IDXW+1:2];
    assign tagF = pcF[31:IDXW+2];
    assign idxU = updPc[IDXW+1:2];
    assign tagU = updPc[31:IDXW+2];

    // Lookup reads the current storage, so a same-cycle update is not yet visible.
    assign hitF      = valid_q[idxF] && (tag_q[idxF] == tagF);
    assign predTaken = hitF && ctr_q[idxF][1];
    assign predPc    = predTaken ? target_q[idxF] : pcF + 32'd4;

    assign hitU      = valid_q[idxU] && (tag_q[idxU] == tagU);
    assign correctPc = updTaken ? updTarget : updPc + 32'd4;

    always_comb begin
        valid_d      = valid_q;
        wrEn         = 1'b0;
        wrTarget     = target_q[idxU];
        wrCtr        = ctr_q[idxU];
        mispredict_d = 1'b0;
        redirectPc_d = redirectPc_q;
        if (updEn) begin
            mispredict_d = (updPredPc != correctPc);
            redirectPc_d = correctPc;
            if (hitU) begin
                wrEn = 1'b1;
                if (updTaken) begin
                    wrCtr    = ctr_inc(ctr_q[idxU]);
                    wrTarget = updTarget;
                end else begin
                    wrCtr    = ctr_dec(ctr_q[idxU]);
                end
            end else if (updTaken) begin
                // Allocation replaces whatever entry aliases to this index.
                wrEn          = 1'b1;
                valid_d[idxU] = 1'b1;
                wrTarget      = updTarget;
                wrCtr         = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            mispredict_q <= 1'b0;
            redirectPc_q <= '0;
        end else begin
            valid_q      <= valid_d;
            mispredict_q <= mispredict_d;
            redirectPc_q <= redirectPc_d;
        end
    end

    // Payload storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tag_q[idxU]    <= tagU;
            target_q[idxU] <= wrTarget;
            ctr_q[idxU]    <= wrCtr;
        end
    end

    assign mispredict = mispredict_q;
    assign redirectPc = redirectPc_q;

    logic unused_bits;
    assign unused_bits = ^{pcF[1:0], updPc[1:0], updPredTaken};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, training, hysteresis,
// target change, aliasing and asynchronous reset.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predTaken;
    logic [31:0] predPc;
    logic        updEn;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;
    logic        updPredTaken;
    logic [31:0] updPredPc;
    logic        mispredict;
    logic [31:0] redirectPc;

    int checks   = 0;
    int failures = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .pcF(pcF),
        .predTaken(predTaken), .predPc(predPc),
        .updEn(updEn), .updPc(updPc), .updTaken(updTaken),
        .updTarget(updTarget), .updPredTaken(updPredTaken),
        .updPredPc(updPredPc),
        .mispredict(mispredict), .redirectPc(redirectPc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ppc);
        updEn = 1'b1; updPc = pc; updTaken = tk; updTarget = tgt;
        updPredTaken = ptk; updPredPc = ppc;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic expTk, input logic [31:0] expPc);
        pcF = pc;
        #1;
        chk({tag, "_tk"}, {31'd0, predTaken}, {31'd0, expTk});
        chk({tag, "_pc"}, predPc, expPc);
    endtask

    task automatic mp(input string tag, input logic expMp, input logic [31:0] expRd);
        chk({tag, "_mp"}, {31'd0, mispredict}, {31'd0, expMp});
        chk({tag, "_rd"}, redirectPc, expRd);
    endtask

    initial begin
        rst = 1'b1; pcF = 32'h100; updEn = 1'b0; updPc = '0; updTaken = 1'b0;
        updTarget = '0; updPredTaken = 1'b0; updPredPc = '0;
        tick(); tick();
        mp("reset", 1'b0, 32'h0);
        rst = 1'b0;
        tick();

        // Cold lookup and a not-taken miss that must not allocate
        lookup("cold", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        tick(); updEn = 1'b0;
        mp("nt_miss", 1'b0, 32'h104);
        lookup("nt_noalloc", 32'h100, 1'b0, 32'h104);

        // Allocate; lookup during the update cycle sees old contents
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        lookup("same_cycle", 32'h100, 1'b0, 32'h104);
        tick(); updEn = 1'b0;
        mp("alloc", 1'b1, 32'h80);
        lookup("alloc", 32'h100, 1'b1, 32'h80);
        tick();
        mp("idle_hold", 1'b0, 32'h80);

        // Hysteresis: 10 -> 11 -> 11, then 10, then 01
        upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        tick(); tick(); updEn = 1'b0;
        mp("tk_correct", 1'b0, 32'h80);
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick(); updEn = 1'b0;
        mp("nt1", 1'b1, 32'h104);
        lookup("nt1", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick(); updEn = 1'b0;
        mp("nt2", 1'b1, 32'h104);
        lookup("nt2", 32'h100, 1'b0, 32'h104);

        // Retrain 01 -> 10 -> 11
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick(); updEn = 1'b0;
        mp("retrain", 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        tick(); updEn = 1'b0;
        mp("retrain2", 1'b0, 32'h80);

        // Right direction, wrong target
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h80);
        tick(); updEn = 1'b0;
        mp("tgt_chg", 1'b1, 32'h200);
        lookup("tgt_chg", 32'h100, 1'b1, 32'h200);

        // Aliasing at index 0
        lookup("alias_miss", 32'h140, 1'b0, 32'h144);
        upd(32'h140, 1'b1, 32'h40, 1'b0, 32'h144);
        tick(); updEn = 1'b0;
        mp("alias", 1'b1, 32'h40);
        lookup("alias_new", 32'h140, 1'b1, 32'h40);
        lookup("alias_old", 32'h100, 1'b0, 32'h104);

        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Async reset between edges discards a pending update
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        mp("pre_rst", 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #2 rst = 1'b1;
        #1;
        mp("async_rst", 1'b0, 32'h0);
        updEn = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        mp("post_rst", 1'b0, 32'h0);
        lookup("post_rst", 32'h100, 1'b0, 32'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
